// File: rtl/dark_channel_gen_if.sv
// Stream interface for dark_channel_gen: RGB888 pixel stream in, dark-channel
// value plus aligned source pixel out.
// Optional macro DARK_CH_FRAME_MAX_EN adds the per-frame dark maximum output.
interface dark_channel_gen_if;

   logic        pix_valid_in;
   logic        pix_sof;
   logic [23:0] picture_data;
   logic        dark_ch_valid;
   logic [7:0]  dark_ch_data;
   logic [23:0] picture_data_out;
   logic        dark_ch_eof;
`ifdef DARK_CH_FRAME_MAX_EN
   logic [7:0]  dark_max_frame;
`endif

`ifdef DARK_CH_FRAME_MAX_EN
   modport master (
      output pix_valid_in, pix_sof, picture_data,
      input  dark_ch_valid, dark_ch_data, picture_data_out, dark_ch_eof, dark_max_frame
   );
   modport slave (
      input  pix_valid_in, pix_sof, picture_data,
      output dark_ch_valid, dark_ch_data, picture_data_out, dark_ch_eof, dark_max_frame
   );
`else
   modport master (
      output pix_valid_in, pix_sof, picture_data,
      input  dark_ch_valid, dark_ch_data, picture_data_out, dark_ch_eof
   );
   modport slave (
      input  pix_valid_in, pix_sof, picture_data,
      output dark_ch_valid, dark_ch_data, picture_data_out, dark_ch_eof
   );
`endif

endinterface

// File: rtl/dark_channel_gen.sv
// dark_channel_gen: per-pixel min(R,G,B) followed by a causal 3x3 minimum
// filter (rows y-2..y, cols x-2..x) using two line buffers. Fixed 3-cycle
// latency, source pixel delayed alongside the result.
// Optional macro DARK_CH_FRAME_MAX_EN adds dark_max_frame, the largest dark
// value seen in the previous completed frame.
module dark_channel_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   dark_channel_gen_if.slave bus
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      logic [7:0] ab;
      ab = (a < b) ? a : b;
      return (ab < c) ? ab : c;
   endfunction

   logic [XW-1:0] r_xCnt;
   logic [YW-1:0] r_yCnt;
   logic [XW-1:0] w_curX;
   logic [YW-1:0] w_curY;

   logic [7:0]    r_line1 [IMG_WIDTH];
   logic [7:0]    r_line2 [IMG_WIDTH];
   logic [7:0]    r_l1Rd;
   logic [7:0]    r_l2Rd;

   logic          r_s1Valid;
   logic [7:0]    r_s1Min;
   logic [XW-1:0] r_s1X;
   logic [YW-1:0] r_s1Y;
   logic [23:0]   r_s1Rgb;

   logic [7:0]    w_l1Tap;
   logic [7:0]    w_l2Tap;
   logic          r_s2Valid;
   logic [7:0]    r_s2Col;
   logic [XW-1:0] r_s2X;
   logic [YW-1:0] r_s2Y;
   logic [23:0]   r_s2Rgb;

   logic [7:0]    r_h1;
   logic [7:0]    r_h2;
   logic [7:0]    w_dark;
   logic          r_outValid;
   logic [7:0]    r_outData;
   logic [23:0]   r_outRgb;
   logic          r_outEof;

   assign w_curX = bus.pix_sof ? '0 : r_xCnt;
   assign w_curY = bus.pix_sof ? '0 : r_yCnt;

   // Raster position of the next expected pixel; sof forces the current pixel to (0,0)
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_xCnt <= '0;
         r_yCnt <= '0;
      end else if (bus.pix_valid_in) begin
         if (w_curX == X_LAST) begin
            r_xCnt <= '0;
            r_yCnt <= (w_curY == Y_LAST) ? '0 : w_curY + 1'b1;
         end else begin
            r_xCnt <= w_curX + 1'b1;
            r_yCnt <= w_curY;
         end
      end
   end

   // Line buffers: address is issued at input time so the synchronous read lands in S2;
   // the read-before-write order means L2 receives the pre-update L1 contents
   always_ff @(posedge sys_clk) begin
      r_l1Rd <= r_line1[w_curX];
      r_l2Rd <= r_line2[w_curX];
      if (r_s1Valid) begin
         r_line1[r_s1X] <= r_s1Min;
         r_line2[r_s1X] <= r_l1Rd;
      end
   end

   // S1: per-pixel minimum of the three colour channels plus position and source word
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_s1Valid <= 1'b0;
      end else begin
         r_s1Valid <= bus.pix_valid_in;
         if (bus.pix_valid_in) begin
            r_s1Min <= min3(bus.picture_data[23:16], bus.picture_data[15:8],
                            bus.picture_data[7:0]);
            r_s1X   <= w_curX;
            r_s1Y   <= w_curY;
            r_s1Rgb <= bus.picture_data;
         end
      end
   end

   // Rows above the top of the image are treated as white so stale line data never leaks
   assign w_l1Tap = (r_s1Y != '0)        ? r_l1Rd : 8'hFF;
   assign w_l2Tap = (r_s1Y > YW'(1))     ? r_l2Rd : 8'hFF;

   // S2: vertical minimum over the three-row column at the current x
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_s2Valid <= 1'b0;
      end else begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Col <= min3(r_s1Min, w_l1Tap, w_l2Tap);
            r_s2X   <= r_s1X;
            r_s2Y   <= r_s1Y;
            r_s2Rgb <= r_s1Rgb;
         end
      end
   end

   // Columns left of the image edge count as white, which also hides the previous row's tail
   assign w_dark = min3(r_s2Col,
                        (r_s2X != '0)    ? r_h1 : 8'hFF,
                        (r_s2X > XW'(1)) ? r_h2 : 8'hFF);

   // S3: horizontal minimum over the last three column results, then the output registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_h1       <= 8'hFF;
         r_h2       <= 8'hFF;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outRgb   <= '0;
         r_outEof   <= 1'b0;
      end else begin
         r_outValid <= r_s2Valid;
         r_outEof   <= r_s2Valid && (r_s2X == X_LAST) && (r_s2Y == Y_LAST);
         if (r_s2Valid) begin
            r_h1      <= r_s2Col;
            r_h2      <= r_h1;
            r_outData <= w_dark;
            r_outRgb  <= r_s2Rgb;
         end
      end
   end

   assign bus.dark_ch_valid    = r_outValid;
   assign bus.dark_ch_data     = r_outData;
   assign bus.picture_data_out = r_outRgb;
   assign bus.dark_ch_eof      = r_outEof;

`ifdef DARK_CH_FRAME_MAX_EN
   logic [7:0] r_runMax;
   logic [7:0] r_maxFrame;
   logic [7:0] w_newMax;

   assign w_newMax = (r_outData > r_runMax) ? r_outData : r_runMax;

   // Running maximum of emitted dark values, published and cleared on the frame's last pixel
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_runMax   <= '0;
         r_maxFrame <= '0;
      end else if (r_outValid) begin
         if (r_outEof) begin
            r_maxFrame <= w_newMax;
            r_runMax   <= '0;
         end else begin
            r_runMax   <= w_newMax;
         end
      end
   end

   assign bus.dark_max_frame = r_maxFrame;
`endif

endmodule

// File: tb/tb_dark_channel_gen.sv
// Self-checking bench for dark_channel_gen on a 4x3 image using directed
// frame tables with hand-computed dark-channel results.
module tb_dark_channel_gen;

   localparam int W = 4;
   localparam int H = 3;
   localparam int NPIX = W * H;

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;

   dark_channel_gen_if bus ();

   dark_channel_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .bus      (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [23:0] pix;
      logic [7:0]  dark;
   } vec_t;

   typedef struct {
      logic [7:0]  dark;
      logic [23:0] rgb;
      logic        eof;
      int          inCycle;
   } exp_t;

   // frame 0: spot of 0x10 at (1,0); frame 1: all black; frame 2: all 0x20
   vec_t        frames [3][NPIX];
   exp_t        expQ [$];
   exp_t        monExp;
   int          testsRun = 0;
   int          testsFailed = 0;
   int          cycleCnt = 0;
   bit          monEn = 1'b0;
   logic [7:0]  lastDark = '0;
   logic [23:0] lastRgb = '0;

   always @(posedge sys_clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic sof, input logic [23:0] pix,
                                input logic [7:0] dark, input logic eof);
      @(posedge sys_clk);
      #1;
      bus.pix_valid_in = valid;
      bus.pix_sof      = sof;
      bus.picture_data = pix;
      if (valid) expQ.push_back('{dark: dark, rgb: pix, eof: eof, inCycle: cycleCnt});
   endtask

   task automatic sendFrame(input int f, input logic useSof, input bit gaps);
      for (int i = 0; i < NPIX; i++) begin
         applyStimulus(1'b1, useSof && (i == 0), frames[f][i].pix, frames[f][i].dark,
                       i == NPIX - 1);
         if (gaps) applyStimulus(1'b0, 1'b0, 24'h0, 8'h0, 1'b0);
      end
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      applyStimulus(1'b0, 1'b0, 24'h0, 8'h0, 1'b0);
      while (expQ.size() != 0 && n < 20) begin
         @(posedge sys_clk);
         n++;
      end
      checkOutput(name, expQ.size(), 0);
      @(posedge sys_clk);
      #1;
   endtask

   // Output monitor: pops the expected queue on each valid output and checks holds otherwise
   always @(negedge sys_clk) begin
      if (monEn) begin
         if (bus.dark_ch_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected output: got dark %0h with nothing pending",
                        bus.dark_ch_data);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("dark data", bus.dark_ch_data, monExp.dark);
               checkOutput("pixel out", bus.picture_data_out, monExp.rgb);
               checkOutput("eof", bus.dark_ch_eof, monExp.eof);
               checkOutput("latency", cycleCnt - monExp.inCycle, 3);
               lastDark = monExp.dark;
               lastRgb  = monExp.rgb;
            end
         end else begin
            checkOutput("valid low", bus.dark_ch_valid, 0);
            checkOutput("hold dark", bus.dark_ch_data, lastDark);
            checkOutput("hold pixel", bus.picture_data_out, lastRgb);
            checkOutput("eof idle", bus.dark_ch_eof, 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < NPIX; i++) begin
         frames[0][i].pix  = (i == 1) ? 24'h101010 : 24'hFFFFFF;
         frames[0][i].dark = (i % W != 0) ? 8'h10 : 8'hFF;
         frames[1][i].pix  = 24'h000000;
         frames[1][i].dark = 8'h00;
         frames[2][i].pix  = 24'h202020;
         frames[2][i].dark = 8'h20;
      end

      bus.pix_valid_in = 1'b0;
      bus.pix_sof      = 1'b0;
      bus.picture_data = 24'h0;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      checkOutput("reset valid", bus.dark_ch_valid, 0);
      checkOutput("reset dark", bus.dark_ch_data, 0);
      checkOutput("reset pixel", bus.picture_data_out, 0);
      checkOutput("reset eof", bus.dark_ch_eof, 0);
`ifdef DARK_CH_FRAME_MAX_EN
      checkOutput("reset frame max", bus.dark_max_frame, 0);
`endif
      monEn = 1'b1;

      $display("[TB] single pixel");
      applyStimulus(1'b1, 1'b1, 24'h8040C0, 8'h40, 1'b0);
      waitDrain("single drain");

      $display("[TB] spot frame, continuous");
      sendFrame(0, 1'b1, 1'b0);
      waitDrain("spot drain");
`ifdef DARK_CH_FRAME_MAX_EN
      checkOutput("frame max spot", bus.dark_max_frame, 8'hFF);
`endif

      $display("[TB] spot frame, alternating valid");
      sendFrame(0, 1'b1, 1'b1);
      waitDrain("gap drain");

      $display("[TB] black frame then grey frame back to back");
      sendFrame(1, 1'b1, 1'b0);
      sendFrame(2, 1'b1, 1'b0);
      waitDrain("b2b drain");
`ifdef DARK_CH_FRAME_MAX_EN
      checkOutput("frame max grey", bus.dark_max_frame, 8'h20);
`endif

      $display("[TB] reset mid row 1");
      for (int i = 0; i < W + 2; i++)
         applyStimulus(1'b1, i == 0, frames[0][i].pix, frames[0][i].dark, 1'b0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      bus.pix_valid_in = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      expQ.delete();
      lastDark = '0;
      lastRgb  = '0;
      checkOutput("midreset valid", bus.dark_ch_valid, 0);
      checkOutput("midreset dark", bus.dark_ch_data, 0);
      checkOutput("midreset pixel", bus.picture_data_out, 0);
`ifdef DARK_CH_FRAME_MAX_EN
      checkOutput("midreset frame max", bus.dark_max_frame, 0);
`endif
      sendFrame(0, 1'b0, 1'b0);
      waitDrain("post reset drain");
`ifdef DARK_CH_FRAME_MAX_EN
      checkOutput("frame max after reset", bus.dark_max_frame, 8'hFF);
`endif

      monEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/dark_channel_gen.md
Name: dark_channel_gen

Overview:
- Upstream stage of the dehazing pipeline; feeds the atmospheric-light estimator.
- Computes the per-pixel minimum of R, G and B, then a causal 3x3 minimum filter over raster-ordered RGB888 video using two line buffers.
- Emits the dark-channel value together with the source RGB pixel, delayed so both stay aligned.
- Streaming, one pixel per valid cycle, no backpressure.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  synchronous active-low reset
- pix_valid_in  in  1  input pixel qualifier
- pix_sof  in  1  start of frame; only meaningful when pix_valid_in=1
- picture_data  in  24  RGB888 input: R=[23:16], G=[15:8], B=[7:0]
- dark_ch_valid  out  1  output qualifier
- dark_ch_data  out  8  dark-channel value
- picture_data_out  out  24  input pixel delayed to align with dark_ch_data
- dark_ch_eof  out  1  high with the last pixel of a frame

Behaviour:
- Reset, applied on a sys_clk edge with sys_rst_n=0:
  - Outputs: dark_ch_valid=0, dark_ch_data=0, picture_data_out=0, dark_ch_eof=0.
  - x_cnt=0, y_cnt=0, all pipeline valids cleared.
  - Line RAM contents are not cleared; y-masking makes them irrelevant.
- Position tracking, updated on each pix_valid_in=1:
  - The current pixel is (x_cnt, y_cnt). When pix_sof=1, that pixel is (0,0) regardless of the counters.
  - x wraps at IMG_WIDTH-1 and then increments y; y wraps at IMG_HEIGHT-1 to 0.
  - pix_sof mid-frame restarts the frame; no error is flagged.
- Pipeline: fixed 3 cycles. An input accepted at cycle N appears at N+3. Stages advance every clock; valid travels with the data. Gaps in pix_valid_in are preserved.
  - S1: m = min(R,G,B), registered together with x, y and the RGB word.
  - S2: read line RAMs L1[x] (row y-1) and L2[x] (row y-2).
    - col = min(m, y>=1 ? L1 : 255, y>=2 ? L2 : 255), registered.
    - Write L2[x] <= L1[x] and L1[x] <= m, only when S1 is valid.
  - S3: keep a horizontal history h1 (previous col) and h2 (col before that). These shift only when S2 is valid.
    - dark = min(col, x>=1 ? h1 : 255, x>=2 ? h2 : 255), registered to dark_ch_data.
- Window: rows y-2..y and cols x-2..x. Out-of-image taps count as 255, so pixel (0,0) outputs m(0,0).
- Line RAMs: IMG_WIDTH x 8 each, with a 1-cycle synchronous read. Read-before-write at the same address; the implementation must return old data.
- dark_ch_eof=1 with the output for (IMG_WIDTH-1, IMG_HEIGHT-1).
- dark_ch_data and picture_data_out hold their last value when dark_ch_valid=0.
- Reset mid-frame: all in-flight pixels are dropped. The next valid pixel is treated as (0,0) even without pix_sof.

Optional Feature:
- Macro: DARK_CH_FRAME_MAX_EN.
- When defined:
  - Extra output port dark_max_frame[7:0], reset to 0.
  - A running max of dark_ch_data is accumulated over each frame.
  - On the dark_ch_eof cycle, dark_max_frame <= max(running, current), and the running value is cleared to 0.
  - This gives the atmospheric-light stage a per-frame brightest-dark-pixel reference.
- When not defined: the port and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=3.
- Single pixel with pix_sof=1, picture_data=0x80_40_C0 -> dark_ch_valid 3 cycles later, dark_ch_data=0x40, picture_data_out=0x8040C0.
- Full frame with every pixel 0xFFFFFF except (1,0)=0x101010 -> dark_ch_data is 0x10 for (1,0), (2,0), (3,0), (1,1), (2,1), (3,1), (1,2), (2,2), (3,2), and 0xFF elsewhere; dark_ch_eof=1 exactly on (3,2).
- Same frame with pix_valid_in toggling 1,0,1,0 -> identical data sequence; each output follows its input by exactly 3 cycles.
- Two back-to-back frames, the second all 0x202020 -> second frame outputs 0x20 everywhere, with no leakage from frame 1 rows (y masking).
- Assert sys_rst_n=0 for 1 cycle mid-row 1, then send 12 pixels without pix_sof -> outputs match a fresh frame and eof lands on the 12th output.
- With DARK_CH_FRAME_MAX_EN defined, frame minima 0x10 and 0xFF -> dark_max_frame=0xFF after eof; a second frame of all 0x202020 gives 0x20.
